// File: rtl/dm_pkg.sv
// Shared encodings and sizing for the data memory and its controller.
package dm_pkg;

  localparam int unsigned DM_WORDS = 1024;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } store_type_e;

  typedef enum logic [2:0] {
    LD_LW   = 3'b000,
    LD_LH   = 3'b001,
    LD_LHU  = 3'b010,
    LD_LB   = 3'b011,
    LD_LBU  = 3'b100,
    LD_RSV5 = 3'b101,
    LD_RSV6 = 3'b110,
    LD_RSV7 = 3'b111
  } load_type_e;

endpackage

// File: rtl/dm_if.sv
// Bundle of the data-memory access signals; master is the issuing pipeline, slave is dm.
interface dm_if;
  logic [31:0] PC;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  StoreType;
  logic [2:0]  LoadType;
  logic [31:0] RD;
  logic        AdEL;
  logic        AdES;

  modport master (
    output PC, Addr, WD, MemWrite, MemRead, StoreType, LoadType,
    input  RD, AdEL, AdES
  );

  modport slave (
    input  PC, Addr, WD, MemWrite, MemRead, StoreType, LoadType,
    output RD, AdEL, AdES
  );
endinterface

// File: rtl/dm_load_ext.sv
// Combinational load path: lane selection, sign/zero extension and legality of the load type.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  output logic [31:0] rd,
  output logic        illegal
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    byte_sel = word[{addr_lo, 3'b000} +: 8];
  end

  always_comb begin
    rd      = '0;
    illegal = 1'b0;
    case (load_type_e'(load_type))
      LD_LW: begin
        illegal = |addr_lo;
        rd      = word;
      end
      LD_LH: begin
        illegal = addr_lo[0];
        rd      = {{16{half_sel[15]}}, half_sel};
      end
      LD_LHU: begin
        illegal = addr_lo[0];
        rd      = {16'h0000, half_sel};
      end
      LD_LB:   rd = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  rd = {24'h000000, byte_sel};
      default: illegal = 1'b1;
    endcase
    // Illegal combinations always read zero, independent of MemRead.
    if (illegal) rd = '0;
  end

endmodule

// File: rtl/dm.sv
// 4 KiB little-endian data memory with byte/half/word stores and combinational loads.
// Optional store logging is enabled by defining DM_WRITE_DISPLAY_EN.
module dm
  import dm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  StoreType,
  input  logic [2:0]  LoadType,
  output logic [31:0] RD,
  output logic        AdEL,
  output logic        AdES
);

  logic [31:0] mem [DM_WORDS];
  logic [9:0]  idx;
  logic [31:0] cur;
  logic [31:0] merged;
  logic        store_bad;
  logic        store_en;
  logic        load_bad;

  // Upper address bits wrap away; PC only feeds the optional log.
  logic unused_ok;
  assign unused_ok = ^{PC, Addr[31:12]};

  assign idx = Addr[11:2];
  assign cur = mem[idx];

  always_comb begin
    merged    = cur;
    store_bad = 1'b0;
    case (store_type_e'(StoreType))
      ST_SW: begin
        store_bad = |Addr[1:0];
        merged    = WD;
      end
      ST_SH: begin
        store_bad = Addr[0];
        if (Addr[1]) merged[31:16] = WD[15:0];
        else         merged[15:0]  = WD[15:0];
      end
      ST_SB:   merged[{Addr[1:0], 3'b000} +: 8] = WD[7:0];
      default: store_bad = 1'b1;
    endcase
  end

  assign AdES     = MemWrite & store_bad;
  assign store_en = MemWrite & ~store_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else if (store_en) begin
      mem[idx] <= merged;
`ifdef DM_WRITE_DISPLAY_EN
      $display("@%08h: *%08h <= %08h", PC, {Addr[31:2], 2'b00}, merged);
`endif
    end
  end

  dm_load_ext u_load_ext (
    .word      (cur),
    .addr_lo   (Addr[1:0]),
    .load_type (LoadType),
    .rd        (RD),
    .illegal   (load_bad)
  );

  assign AdEL = MemRead & load_bad;

endmodule

// File: tb/tb_dm.sv
// Randomized self-checking bench for dm against a byte-array reference model.
module tb_dm;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_if bus ();

  dm u_dm (
    .clk       (clk),
    .reset     (reset),
    .PC        (bus.PC),
    .Addr      (bus.Addr),
    .WD        (bus.WD),
    .MemWrite  (bus.MemWrite),
    .MemRead   (bus.MemRead),
    .StoreType (bus.StoreType),
    .LoadType  (bus.LoadType),
    .RD        (bus.RD),
    .AdEL      (bus.AdEL),
    .AdES      (bus.AdES)
  );

  logic [7:0] mb [4096];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    int unsigned a;
    a = ((addr % 4096) / 4) * 4;
    return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
  endfunction

  function automatic void load_model(input logic [31:0] addr, input logic [2:0] lt,
                                     output logic [31:0] rd, output logic bad);
    int unsigned a, h, b;
    a = addr % 4096;
    bad = 1'b0;
    rd = '0;
    case (lt)
      3'd0: if (a % 4 != 0) bad = 1'b1; else rd = word_at(addr);
      3'd1, 3'd2: begin
        if (a % 2 != 0) bad = 1'b1;
        else begin
          h  = mb[a+1] * 256 + mb[a];
          rd = (lt == 3'd1 && h >= 32768) ? h + 32'hFFFF0000 : h;
        end
      end
      3'd3, 3'd4: begin
        b  = mb[a];
        rd = (lt == 3'd3 && b >= 128) ? b + 32'hFFFFFF00 : b;
      end
      default: bad = 1'b1;
    endcase
  endfunction

  function automatic logic store_bad(input logic [1:0] st, input logic [31:0] addr);
    case (st)
      2'd0:    return (addr % 4) != 0;
      2'd1:    return (addr % 2) != 0;
      2'd2:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic void store_model(input logic [1:0] st, input logic [31:0] addr,
                                      input logic [31:0] wd);
    int unsigned a, n;
    logic [31:0] w;
    a = addr % 4096;
    w = wd;
    n = (st == 2'd0) ? 4 : (st == 2'd1) ? 2 : 1;
    for (int i = 0; i < n; i++) mb[a + i] = w[8*i +: 8];
  endfunction

  task automatic tick();
    logic        rst_now, we;
    logic [1:0]  st;
    logic [31:0] addr, wd;
    rst_now = reset;
    st      = bus.StoreType;
    addr    = bus.Addr;
    wd      = bus.WD;
    we      = bus.MemWrite && !store_bad(st, addr);
    @(posedge clk);
    if (rst_now) for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
    else if (we) store_model(st, addr, wd);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [1:0] st,
                       input logic [2:0] lt, input logic [31:0] addr, input logic [31:0] wd);
    bus.PC        = $urandom;
    bus.MemWrite  = we;
    bus.MemRead   = re;
    bus.StoreType = st;
    bus.LoadType  = lt;
    bus.Addr      = addr;
    bus.WD        = wd;
    #1;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] rd;
    logic        bad;
    load_model(bus.Addr, bus.LoadType, rd, bad);
    check({tag, ".rd"}, bus.RD, rd);
    check({tag, ".adel"}, {31'b0, bus.AdEL}, {31'b0, bus.MemRead & bad});
    check({tag, ".ades"}, {31'b0, bus.AdES},
          {31'b0, bus.MemWrite & store_bad(bus.StoreType, bus.Addr)});
  endtask

  initial begin
    logic [31:0] addrs [3];
    addrs = '{32'h0, 32'h7FC, 32'hFFC};
    for (int i = 0; i < 4096; i++) mb[i] = $urandom;
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;

    // Post-reset reads
    foreach (addrs[i]) begin
      drive(1'b0, 1'b1, ST_SW, LD_LW, addrs[i], 32'h0);
      check("rst_rd", bus.RD, 32'h0);
      check_outputs("rst");
    end

    // Mixed-width stores into one word
    drive(1'b1, 1'b0, ST_SW, LD_LW, 32'h10, 32'h89ABCDEF); tick();
    drive(1'b1, 1'b0, ST_SB, LD_LW, 32'h12, 32'h00000011); tick();
    drive(1'b1, 1'b0, ST_SH, LD_LW, 32'h10, 32'h00002233); tick();
    drive(1'b0, 1'b1, ST_SW, LD_LW,  32'h10, 32'h0); check("lw10", bus.RD, 32'h89112233);
    drive(1'b0, 1'b1, ST_SW, LD_LB,  32'h13, 32'h0); check("lb13", bus.RD, 32'hFFFFFF89);
    drive(1'b0, 1'b1, ST_SW, LD_LBU, 32'h13, 32'h0); check("lbu13", bus.RD, 32'h00000089);
    drive(1'b0, 1'b1, ST_SW, LD_LHU, 32'h12, 32'h0); check("lhu12", bus.RD, 32'h00008911);
    check_outputs("lhu12m");

    // Misaligned stores are blocked, misaligned load flagged
    drive(1'b1, 1'b0, ST_SW, LD_LW, 32'h16, 32'hDEADBEEF);
    check("ades_sw", {31'b0, bus.AdES}, 32'h1); tick();
    drive(1'b1, 1'b0, ST_SH, LD_LW, 32'h11, 32'h0000BEEF);
    check("ades_sh", {31'b0, bus.AdES}, 32'h1); tick();
    drive(1'b0, 1'b1, ST_SW, LD_LW, 32'h14, 32'h0); check("w14_keep", bus.RD, 32'h0);
    drive(1'b0, 1'b1, ST_SW, LD_LW, 32'h10, 32'h0); check("w10_keep", bus.RD, 32'h89112233);
    drive(1'b0, 1'b1, ST_SW, LD_LW, 32'h16, 32'h0);
    check("adel_lw", {31'b0, bus.AdEL}, 32'h1);
    check("adel_rd", bus.RD, 32'h0);
    drive(1'b0, 1'b0, ST_SW, 3'd5, 32'h10, 32'h0);
    check("rsv_rd", bus.RD, 32'h0);
    check_outputs("rsv");

    // Address wrap
    drive(1'b1, 1'b0, ST_SW, LD_LW, 32'h1004, 32'h12345678); tick();
    drive(1'b0, 1'b1, ST_SW, LD_LW, 32'h4, 32'h0); check("wrap", bus.RD, 32'h12345678);

    // Reset overrides a concurrent store
    reset = 1'b1;
    drive(1'b1, 1'b1, ST_SW, LD_LW, 32'h20, 32'hFFFFFFFF); tick();
    reset = 1'b0;
    drive(1'b0, 1'b1, ST_SW, LD_LW, 32'h20, 32'h0); check("rst_store", bus.RD, 32'h0);

    // Same-cycle store and read
    drive(1'b1, 1'b1, ST_SW, LD_LW, 32'h24, 32'hCAFEF00D);
    check("rw_before", bus.RD, 32'h0); tick();
    check("rw_after", bus.RD, 32'hCAFEF00D);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] addr;
      addr  = $urandom_range(0, 63) | ($urandom & 32'hFFFFF000);
      reset = ($urandom_range(0, 59) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), addr, $urandom);
      check_outputs("rnd");
      tick();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
